keypad_scanner: RTL and testbench
=================================

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 1000, clock cycles each column is driven (legal 4..65535).
REQ-002 SHALL have parameter DEBOUNCE_FRAMES, default 4, consecutive identical scan frames needed to change the reported key (legal 1..15).
REQ-003 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port row_n  input  4  keypad rows, active-low, externally pulled up, asynchronous to clk.
REQ-006 SHALL have port col_n  output  3  keypad column drive, active-low, exactly one bit low at all times.
REQ-007 SHALL have port key  output  4  debounced key code, level, feeds the alarm clock key input.
REQ-008 SHALL have port key_strobe  output  1  one-cycle pulse when key changes to a non-NOKEY code.

Function
REQ-009 SHALL use key map row0: 1 2 3; row1: 4 5 6; row2: 7 8 9; row3: * 0 # (columns 0,1,2 left to right); digits encode as 4'd0..4'd9; NOKEY = 4'hA.
REQ-010 SHALL pass row_n through a two-flop synchronizer before any use.
REQ-011 SHALL drive columns in order 0,1,2,0,...; each for SCAN_DIV cycles via a period counter; three periods form one frame.
REQ-012 SHALL sample synchronized rows on the last cycle of each column period only.
REQ-013 SHALL classify each frame at its end: exactly one active row/column intersection -> that key's code; none -> NOKEY; two or more -> NOKEY (ghost/multi-press rejection).
REQ-014 SHALL implement state machine STABLE, CANDIDATE: STABLE -> CANDIDATE when frame code differs from key; CANDIDATE counts consecutive frames equal to the candidate code; a differing frame restarts the count with the new code (returning to STABLE if it equals key).
REQ-015 SHALL update key on the clock edge following classification of the DEBOUNCE_FRAMES-th consecutive identical candidate frame, then return to STABLE.
REQ-016 SHALL assert key_strobe for exactly that one cycle when the new key is not NOKEY, including a direct change between two different keys; release (-> NOKEY) SHALL NOT strobe.
REQ-017 SHALL hold key constant while a key stays pressed; no auto-repeat strobes.
REQ-018 SHALL wrap the period counter at SCAN_DIV-1 and the column index at 2 without skipped or extra cycles.

Reset
REQ-019 SHALL, while reset is low, force key = 4'hA, key_strobe = 0, col_n = 3'b110, counters and synchronizer to idle, state STABLE.
REQ-020 SHALL, on reset assertion mid-frame or mid-debounce, discard partial frame and candidate; scanning restarts at column 0 on the first clk edge after release.

Configuration
REQ-021 SHALL honour macro KEYPAD_STAR_HASH_EN: defined -> * reports 4'hB and # reports 4'hC, debounced and strobed like digits; undefined -> * and # positions contribute nothing to classification (a frame with only * or # is NOKEY; * plus a digit reports the digit).

Verification (SCAN_DIV=4, DEBOUNCE_FRAMES=2, frame = 12 cycles)
REQ-022 SHALL cover: reset low -> key=4'hA, key_strobe=0, col_n=3'b110; after release col_n steps 110,101,011 every 4 cycles.
REQ-023 SHALL cover: hold "5" (row1 low while col_n[1] low) from frame start -> key=4'd5 with one key_strobe pulse at end of second full frame plus one cycle; held 10 frames -> no further strobes.
REQ-024 SHALL cover: "5" pressed for one frame only -> key stays 4'hA, no strobe; release after valid press -> key=4'hA two frames later, no strobe.
REQ-025 SHALL cover: "1" and "9" pressed together -> key stays 4'hA; "3" held then switched directly to "0" -> key 3 -> 0 with a strobe at each change.
REQ-026 SHALL cover: press "#" -> key=4'hC with strobe when KEYPAD_STAR_HASH_EN defined, key stays 4'hA when undefined.
REQ-027 SHALL cover: reset asserted one frame into debouncing "7" -> key=4'hA, counters cleared; "7" still held after release -> key=4'd7 only after two fresh full frames.

Source files
------------

// File: rtl/keypad_scanner.sv
// 4x3 matrix keypad scanner with frame-based ghost rejection and debouncing.
// Define KEYPAD_STAR_HASH_EN to report * as 4'hB and # as 4'hC; otherwise those keys are ignored.
module keypad_scanner #(
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row_n,
    output logic [2:0] col_n,
    output logic [3:0] key,
    output logic       key_strobe
);

    localparam logic [3:0]  NOKEY    = 4'hA;
    localparam logic [15:0] LAST_CNT = 16'(SCAN_DIV - 1);
    localparam logic [3:0]  DF       = 4'(DEBOUNCE_FRAMES);

    typedef enum logic [0:0] {STABLE, CANDIDATE} state_t;

    logic [3:0]  row_meta_q, row_sync_q;
    logic [15:0] period_q;
    logic [1:0]  col_q;
    logic [1:0]  hits_q;
    logic [3:0]  code_q;
    logic [3:0]  frame_code_q;
    logic        frame_valid_q;
    state_t      state_q, state_d;
    logic [3:0]  cand_q, cand_d;
    logic [3:0]  run_q, run_d;
    logic [3:0]  key_q, key_d;
    logic        strobe_q, strobe_d;

    logic        last_cycle, frame_end;
    logic [1:0]  col_hits;
    logic [3:0]  col_code;
    logic [2:0]  hit_sum;
    logic [3:0]  code_sel;
    logic [3:0]  frame_code;

    // Returns {valid, code} for the key at a row/column intersection.
    function automatic logic [4:0] key_at(input logic [1:0] row, input logic [1:0] col);
        logic [4:0] k;
        k = {1'b0, NOKEY};
        case ({row, col})
            4'b00_00: k = {1'b1, 4'd1};
            4'b00_01: k = {1'b1, 4'd2};
            4'b00_10: k = {1'b1, 4'd3};
            4'b01_00: k = {1'b1, 4'd4};
            4'b01_01: k = {1'b1, 4'd5};
            4'b01_10: k = {1'b1, 4'd6};
            4'b10_00: k = {1'b1, 4'd7};
            4'b10_01: k = {1'b1, 4'd8};
            4'b10_10: k = {1'b1, 4'd9};
            4'b11_01: k = {1'b1, 4'd0};
`ifdef KEYPAD_STAR_HASH_EN
            4'b11_00: k = {1'b1, 4'hB};
            4'b11_10: k = {1'b1, 4'hC};
`else
            4'b11_00: k = {1'b0, NOKEY};
            4'b11_10: k = {1'b0, NOKEY};
`endif
            default:  k = {1'b0, NOKEY};
        endcase
        return k;
    endfunction

    assign last_cycle = (period_q == LAST_CNT);
    assign frame_end  = last_cycle && (col_q == 2'd2);
    assign col_n      = ~(3'b001 << col_q);
    assign key        = key_q;
    assign key_strobe = strobe_q;

    always_comb begin
        logic [4:0] k;
        col_hits = 2'd0;
        col_code = NOKEY;
        k        = 5'd0;
        for (int r = 0; r < 4; r++) begin
            if (!row_sync_q[r]) begin
                k = key_at(2'(r), col_q);
                if (k[4]) begin
                    if (col_hits != 2'd2) col_hits = col_hits + 2'd1;
                    col_code = k[3:0];
                end
            end
        end
        hit_sum    = {1'b0, hits_q} + {1'b0, col_hits};
        code_sel   = (col_hits != 2'd0) ? col_code : code_q;
        frame_code = (hit_sum == 3'd1) ? code_sel : NOKEY;
    end

    // Hit counts saturate at two, which is all the classifier needs to reject multi-press.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_meta_q    <= 4'hF;
            row_sync_q    <= 4'hF;
            period_q      <= '0;
            col_q         <= 2'd0;
            hits_q        <= 2'd0;
            code_q        <= NOKEY;
            frame_code_q  <= NOKEY;
            frame_valid_q <= 1'b0;
        end else begin
            row_meta_q    <= row_n;
            row_sync_q    <= row_meta_q;
            frame_valid_q <= frame_end;
            if (last_cycle) begin
                period_q <= '0;
                col_q    <= (col_q == 2'd2) ? 2'd0 : col_q + 2'd1;
                if (frame_end) begin
                    hits_q       <= 2'd0;
                    code_q       <= NOKEY;
                    frame_code_q <= frame_code;
                end else begin
                    hits_q <= (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
                    code_q <= code_sel;
                end
            end else begin
                period_q <= period_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= STABLE;
            cand_q   <= NOKEY;
            run_q    <= 4'd0;
            key_q    <= NOKEY;
            strobe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cand_q   <= cand_d;
            run_q    <= run_d;
            key_q    <= key_d;
            strobe_q <= strobe_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cand_d   = cand_q;
        run_d    = run_q;
        key_d    = key_q;
        strobe_d = 1'b0;
        if (frame_valid_q) begin
            case (state_q)
                STABLE: begin
                    if (frame_code_q != key_q) begin
                        if (DEBOUNCE_FRAMES == 1) begin
                            key_d    = frame_code_q;
                            strobe_d = (frame_code_q != NOKEY);
                        end else begin
                            cand_d  = frame_code_q;
                            run_d   = 4'd1;
                            state_d = CANDIDATE;
                        end
                    end
                end
                CANDIDATE: begin
                    if (frame_code_q == cand_q) begin
                        if (run_q + 4'd1 >= DF) begin
                            key_d    = cand_q;
                            strobe_d = (cand_q != NOKEY);
                            state_d  = STABLE;
                        end else begin
                            run_d = run_q + 4'd1;
                        end
                    end else if (frame_code_q == key_q) begin
                        state_d = STABLE;
                    end else begin
                        cand_d = frame_code_q;
                        run_d  = 4'd1;
                    end
                end
                default: state_d = STABLE;
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Randomized scoreboard bench for keypad_scanner: an ideal keypad drives the rows,
// a frame-level model predicts key levels and strobes, and a monitor compares.
module tb_keypad_scanner;

   localparam int SCAN = 4;
   localparam int DF = 2;
   localparam int FRAME = 3 * SCAN;

   typedef struct {
      int cycle;
      logic [3:0] code;
   } exp_t;

   logic clk;
   logic rstN;
   logic [3:0] rowN;
   logic [2:0] colN;
   logic [3:0] keyOut;
   logic keyStrobe;

   logic [11:0] pressed;
   int cyc;
   int errors;
   int checks;
   exp_t strobeQ[$];
   exp_t levelQ[$];
   logic done;
   logic finished;

   int frameIdx;
   logic [3:0] keyModel;
   logic [3:0] runCode;
   int runLen;

   keypad_scanner #(.SCAN_DIV(SCAN), .DEBOUNCE_FRAMES(DF)) dut (
      .clk(clk),
      .reset(rstN),
      .row_n(rowN),
      .col_n(colN),
      .key(keyOut),
      .key_strobe(keyStrobe)
   );

   // Clock with a 10-unit period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Ideal keypad: a pressed key pulls its row low while its column is driven low.
   always_comb begin
      rowN = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 3; c++)
            if (pressed[r * 3 + c] && !colN[c]) rowN[r] = 1'b0;
   end

   // Edges elapsed since reset release, used to place every expectation in time.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) cyc <= 0;
      else cyc <= cyc + 1;
   end

   // Key codes by position r*3+c, straight from the keypad legend.
   function automatic logic [3:0] codeOf(input int idx);
      case (idx)
         9: return 4'hB;
         10: return 4'd0;
         11: return 4'hC;
         default: return 4'(idx + 1);
      endcase
   endfunction

   function automatic bit reportable(input int idx);
`ifdef KEYPAD_STAR_HASH_EN
      return 1'b1;
`else
      return (idx != 9) && (idx != 11);
`endif
   endfunction

   function automatic logic [3:0] classify(input logic [11:0] mask);
      int n;
      logic [3:0] code;
      n = 0;
      code = 4'hA;
      for (int i = 0; i < 12; i++)
         if (mask[i] && reportable(i)) begin
            n++;
            code = codeOf(i);
         end
      return (n == 1) ? code : 4'hA;
   endfunction

   task automatic resetModel();
      keyModel = 4'hA;
      runCode = 4'hA;
      runLen = 0;
      frameIdx = 0;
   endtask

   // The key follows any code that has been seen in DF consecutive frames.
   task automatic modelFrameEnd(input logic [3:0] code);
      if (code == runCode) runLen++;
      else begin
         runCode = code;
         runLen = 1;
      end
      if (runLen >= DF && runCode != keyModel) begin
         keyModel = runCode;
         if (runCode != 4'hA) strobeQ.push_back('{FRAME * (frameIdx + 1) + 1, runCode});
      end
   endtask

   // Entered on the negedge just after a frame starts; returns on the next frame's first negedge.
   task automatic applyStimulus(input logic [11:0] mask, input int frames);
      for (int f = 0; f < frames; f++) begin
         pressed = mask;
         levelQ.push_back('{FRAME * frameIdx + 1, keyModel});
         @(posedge clk);
         @(negedge clk);
         repeat (FRAME - 1) @(posedge clk);
         modelFrameEnd(classify(mask));
         frameIdx++;
         @(negedge clk);
      end
   endtask

   function automatic logic [11:0] keyMask(input int idx);
      logic [11:0] one;
      one = 12'd1;
      return one << idx;
   endfunction

   // Monitor: owns every comparison, popping expectations when their cycle comes up.
   task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] required);
      checks++;
      if (actual !== required) begin
         errors++;
         $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, actual, required);
      end
   endtask

   initial begin
      logic rstPrev;
      logic expStrobe;
      errors = 0;
      checks = 0;
      finished = 1'b0;
      rstPrev = 1'b1;
      forever begin
         @(negedge clk);
         if (!rstN) begin
            if (!rstPrev) begin
               checkOutput("reset_key", {4'h0, keyOut}, 8'h0A);
               checkOutput("reset_strobe", {7'h0, keyStrobe}, 8'h00);
               checkOutput("reset_col", {5'h0, colN}, 8'h06);
            end
         end else begin
            checkOutput("col_n", {5'h0, colN}, {5'h0, ~(3'b001 << ((cyc / SCAN) % 3))});
            expStrobe = (strobeQ.size() > 0) && (strobeQ[0].cycle == cyc);
            checkOutput("key_strobe", {7'h0, keyStrobe}, {7'h0, expStrobe});
            if (expStrobe) begin
               checkOutput("strobe_key", {4'h0, keyOut}, {4'h0, strobeQ[0].code});
               void'(strobeQ.pop_front());
            end
            if (levelQ.size() > 0 && levelQ[0].cycle == cyc) begin
               checkOutput("key_level", {4'h0, keyOut}, {4'h0, levelQ[0].code});
               void'(levelQ.pop_front());
            end
            if (done && !finished) begin
               checkOutput("pending_expectations", 8'(strobeQ.size() + levelQ.size()), 8'h00);
               finished = 1'b1;
            end
         end
         rstPrev = rstN;
      end
   end

   initial begin
      int kind, hold, a, b;
      logic [11:0] mask;
      done = 1'b0;
      pressed = 12'd0;
      rstN = 1'b0;
      resetModel();
      repeat (4) @(negedge clk);
      rstN = 1'b1;

      // Directed: valid press and hold, release, short press, ghost, key-to-key change.
      applyStimulus(keyMask(4), 10);
      applyStimulus(12'd0, 3);
      applyStimulus(keyMask(4), 1);
      applyStimulus(12'd0, 2);
      applyStimulus(keyMask(0) | keyMask(8), 3);
      applyStimulus(keyMask(2), 3);
      applyStimulus(keyMask(10), 3);
      applyStimulus(12'd0, 2);
      applyStimulus(keyMask(11), 3);
      applyStimulus(keyMask(9) | keyMask(5), 3);
      applyStimulus(12'd0, 2);

      // Reset in the middle of debouncing "7" discards the partial progress.
      applyStimulus(keyMask(6), 1);
      pressed = keyMask(6);
      repeat (5) @(posedge clk);
      @(negedge clk);
      rstN = 1'b0;
      repeat (3) @(negedge clk);
      rstN = 1'b1;
      resetModel();
      applyStimulus(keyMask(6), 3);
      applyStimulus(12'd0, 2);

      // Random presses: idle, single keys, pairs, with random hold lengths.
      for (int n = 0; n < 60; n++) begin
         kind = $urandom_range(0, 3);
         hold = $urandom_range(1, 3);
         a = $urandom_range(0, 11);
         b = $urandom_range(0, 11);
         case (kind)
            0: mask = 12'd0;
            1: mask = keyMask(a);
            2: mask = keyMask(a) | keyMask(b);
            default: mask = keyMask($urandom_range(0, 8));
         endcase
         applyStimulus(mask, hold);
      end
      applyStimulus(12'd0, 2);

      done = 1'b1;
      for (int i = 0; i < 20 && !finished; i++) @(negedge clk);
      if (!finished) begin
         $display("[TB] FAIL monitor_timeout: monitor did not acknowledge completion");
         $fatal(1, "[TB] monitor timeout");
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
